// File: rtl/load_hazard_scoreboard_pkg.sv
// Shared pipeline definitions: memory-op encodings and register specifier type.
package pipeline_pkg;

    localparam int REG_ADDR_W_DEFAULT = 3;

    typedef logic [REG_ADDR_W_DEFAULT-1:0] reg_addr_t;
    typedef logic [1:0]                    mem_op_t;

    localparam mem_op_t MEM_OP_NONE  = 2'b00;
    localparam mem_op_t MEM_OP_LOAD  = 2'b01;
    localparam mem_op_t MEM_OP_STORE = 2'b10;

    function automatic logic is_load(input mem_op_t op);
        return op == MEM_OP_LOAD;
    endfunction

endpackage

// File: rtl/load_hazard_scoreboard_if.sv
// Handshake bundle between the pipeline control and the load-use hazard scoreboard.
interface load_hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 3,
    parameter int NUM_REGS   = 8,
    parameter int CNT_W      = 16
);
    import pipeline_pkg::*;

    mem_op_t               id_ex_mem_op;
    logic [REG_ADDR_W-1:0] id_ex_rt;
    logic                  id_ex_valid;
    logic [REG_ADDR_W-1:0] if_id_rs;
    logic [REG_ADDR_W-1:0] if_id_rt;
    logic                  if_id_valid;
    logic                  flush;
    logic                  mem_stall;
    logic                  stall;
    logic [NUM_REGS-1:0]   pending;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_ex_mem_op, id_ex_rt, id_ex_valid,
        output if_id_rs, if_id_rt, if_id_valid,
        output flush, mem_stall,
        input  stall, pending, stall_cycles
    );

    modport slave (
        input  id_ex_mem_op, id_ex_rt, id_ex_valid,
        input  if_id_rs, if_id_rt, if_id_valid,
        input  flush, mem_stall,
        output stall, pending, stall_cycles
    );

endinterface

// File: rtl/load_hazard_scoreboard_hazard_countdown.sv
// Per-register load countdown: reload on issue, decrement toward zero unless frozen.
module hazard_countdown #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         freeze,
    input  logic [W-1:0] reload_val,
    output logic         busy
);

    logic [W-1:0] cnt;

    // A new issue wins over the decrement of the same entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= reload_val;
        end else if (!freeze && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign busy = cnt != '0;

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard controller with per-register countdowns, freeze/flush handling and a stall counter.
module load_hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W         = 3,
    parameter int NUM_REGS           = 8,
    parameter int LOAD_LAT           = 1,
    parameter bit ZERO_REG_HARDWIRED = 1'b0,
    parameter int CNT_W              = 16
) (
    input logic                     clk,
    input logic                     reset,
    load_hazard_scoreboard_if.slave hz
);

    localparam int            TW     = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
    localparam logic [TW-1:0] RELOAD = TW'(LOAD_LAT - 1);

    logic                id_ex_load;
    logic                issue;
    logic [NUM_REGS-1:0] busy;
    logic                src_a_hit;
    logic                src_b_hit;
    logic [CNT_W-1:0]    stall_count;

    function automatic logic reg_hit(
        input logic [REG_ADDR_W-1:0] x,
        input logic [NUM_REGS-1:0]   busy_v,
        input logic                  ld,
        input logic [REG_ADDR_W-1:0] ld_rt
    );
        logic h;
        h = busy_v[x] || (ld && ld_rt == x);
        if (ZERO_REG_HARDWIRED && x == '0) begin
            h = 1'b0;
        end
        return h;
    endfunction

    // The ID/EX load is visible as a hazard even while frozen; only recording waits for !mem_stall.
    assign id_ex_load = hz.id_ex_valid && is_load(hz.id_ex_mem_op) && !hz.flush;
    assign issue      = id_ex_load && !hz.mem_stall;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        hazard_countdown #(
            .W(TW)
        ) u_cd (
            .clk       (clk),
            .reset     (reset),
            .load      (issue && hz.id_ex_rt == REG_ADDR_W'(r)),
            .freeze    (hz.mem_stall),
            .reload_val(RELOAD),
            .busy      (busy[r])
        );
    end

    always_comb begin
        src_a_hit = reg_hit(hz.if_id_rs, busy, id_ex_load, hz.id_ex_rt);
        src_b_hit = reg_hit(hz.if_id_rt, busy, id_ex_load, hz.id_ex_rt);
    end

    assign hz.stall = !reset && hz.if_id_valid && (src_a_hit || src_b_hit);

    // Frozen cycles are not attributed to the load-use hazard.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (hz.stall && !hz.mem_stall && stall_count != '1) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign hz.pending      = busy;
    assign hz.stall_cycles = stall_count;

endmodule

// File: doc/load_hazard_scoreboard.md
# load_hazard_scoreboard

Parametrised load-use hazard controller for the in-order pipeline. It sits between the IF/ID and ID/EX stages and asserts `stall` while a source register of the instruction in IF/ID waits on a load result. Unlike a single-cycle load-use check, it tracks each destination register with its own countdown, so loads of any fixed memory latency are supported. It also honours pipeline freeze and flush, and keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- `REG_ADDR_W`, 3: register specifier width.
- `NUM_REGS`, 8: number of architectural registers, equal to 2**REG_ADDR_W.
- `LOAD_LAT`, 1: cycles a dependant must stall after its load enters ID/EX. Minimum 1. Value 1 gives classic one-bubble load-use behaviour.
- `ZERO_REG_HARDWIRED`, 0: when 1, register 0 never creates a hazard.
- `CNT_W`, 16: width of the stall-cycle counter.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `id_ex_mem_op`, input, 2: memory op of the ID/EX instruction. 00 none, 01 load, 10 store.
- `id_ex_rt`, input, REG_ADDR_W: load destination register.
- `id_ex_valid`, input, 1: the ID/EX slot holds a real instruction (not a bubble).
- `if_id_rs`, input, REG_ADDR_W: source register A of the instruction in IF/ID.
- `if_id_rt`, input, REG_ADDR_W: source register B of the instruction in IF/ID.
- `if_id_valid`, input, 1: the IF/ID slot holds a real instruction.
- `flush`, input, 1: the ID/EX instruction is squashed this cycle.
- `mem_stall`, input, 1: global pipeline freeze.
- `stall`, output, 1: hold PC and IF/ID, insert a bubble into ID/EX.
- `pending`, output, NUM_REGS: bit r is 1 when the countdown for register r is nonzero.
- `stall_cycles`, output, CNT_W: saturating count of stall cycles.

## Operation
- Per-register countdown `cnt[r]` has width clog2(LOAD_LAT+1).
- `issue` = id_ex_valid & (id_ex_mem_op == 01) & !flush & !mem_stall.
- On issue, at the clock edge: `cnt[id_ex_rt]` <= LOAD_LAT-1. The issue load overrides any decrement of the same entry in that cycle. A re-load of an already pending register also reloads LOAD_LAT-1.
- Other nonzero entries decrement by 1 each cycle while !mem_stall. They hold while mem_stall=1.
- `hit(x)` = (cnt[x] != 0) | (id_ex_valid & id_ex_mem_op == 01 & !flush & id_ex_rt == x). When ZERO_REG_HARDWIRED=1, hit(x) is masked to 0 for x == 0.
- `stall` = if_id_valid & (hit(if_id_rs) | hit(if_id_rt)). It is combinational, and the ID/EX term is evaluated even while mem_stall is active.
- Result: an immediately dependent instruction stalls exactly LOAD_LAT cycles, excluding mem_stall cycles.
- Stores and non-memory ops never set an entry.
- `stall_cycles` increments when stall & !mem_stall, and saturates at all-ones.

## Timing
- `stall` has zero latency from its inputs. `pending` and `stall_cycles` are registered.
- Reset values: all `cnt` = 0, `pending` = 0, `stall_cycles` = 0. `stall` is forced to 0 while reset=1.
- Reset mid-countdown clears all entries on that edge. The first post-reset cycle has no hazards unless a load currently sits in ID/EX.
- flush during the issue cycle: nothing is recorded and there is no ID/EX hit. Entries already counting are unaffected.
- flush and mem_stall together: no issue and no decrement.

## Structure
- Shared package `pipeline_pkg` holds the mem-op encodings `MEM_OP_NONE`/`MEM_OP_LOAD`/`MEM_OP_STORE` and the `reg_addr_t` typedef.
- One sub-module, `hazard_countdown`: a single register's counter with load, decrement and freeze controls. It is instantiated NUM_REGS times via generate.

## Test plan
- LOAD_LAT=1: load to r3 in ID/EX, IF/ID reads rs=r3 -> stall=1 for one cycle, then 0. `stall_cycles` = 1.
- LOAD_LAT=3: load to r5, dependant on rt=r5 follows -> stall for 3 cycles. `pending[5]` is 1 for 2 cycles after issue.
- LOAD_LAT=3: mem_stall asserted for 2 cycles mid-countdown -> stall lasts 5 cycles in total. `stall_cycles` = 3.
- flush with load to r2 in ID/EX while IF/ID reads r2 -> stall=0 and `pending[2]` stays 0.
- ZERO_REG_HARDWIRED=1: load to r0, dependant reads r0 -> stall never asserts.
- Reset asserted with `pending[4]` set -> next cycle `pending` = 0, `stall_cycles` = 0, and a dependant on r4 does not stall. Saturation check: preload near all-ones with CNT_W=4 -> counter sticks at 15.
